// File: rtl/acc_writeback_serializer.sv
// Drains the systolic accumulator bank into DP RAM port B as byte writes,
// either full-width little-endian or requantized to saturated int8.
module acc_writeback_serializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int MATRIX_SIZE    = 8,
  parameter int ACC_WIDTH      = 32,
  parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE*MATRIX_SIZE),
  parameter int DP_ADDR_WIDTH  = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DP_ADDR_WIDTH-1:0]  base_addr,
  input  logic                      pack_int8,
  input  logic [4:0]                shift_amt,
  output logic                      busy,
  output logic                      done,
  output logic                      wrap_flag,
  output logic [ACC_ADDR_WIDTH-1:0] addr_acc,
  input  logic [ACC_WIDTH-1:0]      acc_out,
  output logic                      we_b,
  output logic [DP_ADDR_WIDTH-1:0]  addr_b,
  output logic [DATA_WIDTH-1:0]     din_b
);

  localparam int BYTES = ACC_WIDTH / DATA_WIDTH;
  localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ACC_ADDR_WIDTH-1:0] LAST_ELEM = ACC_ADDR_WIDTH'(MATRIX_SIZE*MATRIX_SIZE-1);
  localparam logic [BIW-1:0]            LAST_BYTE = BIW'(BYTES-1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(127);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -ACC_WIDTH'(128);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE} state_t;

  state_t                               state;
  logic [BYTES-1:0][DATA_WIDTH-1:0]     hold_reg;
  logic [ACC_ADDR_WIDTH-1:0]            elem_idx;
  logic [BIW-1:0]                       byte_idx;
  logic [DP_ADDR_WIDTH-1:0]             wr_ptr;
  logic                                 wrapped;
  logic                                 pack_r;
  logic [4:0]                           shift_r;

  logic signed [ACC_WIDTH-1:0]          shifted;
  logic [DATA_WIDTH-1:0]                sat_byte;
  logic                                 last_byte;

  // Clamped value fits in 8 signed bits, so the low DATA_WIDTH bits are its
  // two's complement (sign-extended) encoding.
  always_comb begin
    shifted  = $signed(hold_reg) >>> shift_r;
    sat_byte = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX)      sat_byte = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) sat_byte = SAT_MIN[DATA_WIDTH-1:0];
  end

  assign last_byte = pack_r || (byte_idx == LAST_BYTE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap_flag <= 1'b0;
      we_b      <= 1'b0;
      addr_acc  <= '0;
      addr_b    <= '0;
      din_b     <= '0;
      hold_reg  <= '0;
      elem_idx  <= '0;
      byte_idx  <= '0;
      wr_ptr    <= '0;
      wrapped   <= 1'b0;
      pack_r    <= 1'b0;
      shift_r   <= '0;
    end else begin
      done <= 1'b0;
      we_b <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          pack_r    <= pack_int8;
          shift_r   <= shift_amt;
          wr_ptr    <= base_addr;
          elem_idx  <= '0;
          addr_acc  <= '0;
          wrap_flag <= 1'b0;
          wrapped   <= 1'b0;
          busy      <= 1'b1;
          state     <= S_READ;
        end
        // addr_acc is already stable here, giving a registered bank one cycle
        S_READ: state <= S_CAPTURE;
        S_CAPTURE: begin
          hold_reg <= acc_out;
          byte_idx <= '0;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          we_b   <= 1'b1;
          addr_b <= wr_ptr;
          din_b  <= pack_r ? sat_byte : hold_reg[byte_idx];
          wr_ptr <= wr_ptr + DP_ADDR_WIDTH'(1);
          if (&wr_ptr) wrapped   <= 1'b1;
          if (wrapped) wrap_flag <= 1'b1;
          if (last_byte) begin
            if (elem_idx == LAST_ELEM) begin
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              elem_idx <= elem_idx + ACC_ADDR_WIDTH'(1);
              addr_acc <= elem_idx + ACC_ADDR_WIDTH'(1);
              state    <= S_READ;
            end
          end else begin
            byte_idx <= byte_idx + BIW'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_writeback_serializer.sv
// Directed bench: queue-based byte-stream model plus literal spot checks.
module tb_acc_writeback_serializer;
  localparam int DW = 8, MS = 8, AW = 32, AAW = 6, DAW = 10, N = MS*MS;

  logic clk = 1'b0;
  logic rst, start, pack_int8;
  logic [DAW-1:0] base_addr;
  logic [4:0]     shift_amt;
  logic busy, done, wrap_flag, we_b;
  logic [AAW-1:0] addr_acc;
  logic [AW-1:0]  acc_out;
  logic [DAW-1:0] addr_b;
  logic [DW-1:0]  din_b;

  int errors = 0, checks = 0;
  logic [AW-1:0] acc_mem [N];
  logic [DW-1:0] ram [1024];
  int last_addr = -1;

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  wr_t w_chk;

  always #5 clk = ~clk;
  assign acc_out = acc_mem[addr_acc];

  acc_writeback_serializer #(
    .DATA_WIDTH(DW), .MATRIX_SIZE(MS), .ACC_WIDTH(AW),
    .ACC_ADDR_WIDTH(AAW), .DP_ADDR_WIDTH(DAW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .pack_int8(pack_int8), .shift_amt(shift_amt), .busy(busy), .done(done),
    .wrap_flag(wrap_flag), .addr_acc(addr_acc), .acc_out(acc_out),
    .we_b(we_b), .addr_b(addr_b), .din_b(din_b)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write seen on port B must be the next entry of the model stream.
  always @(negedge clk) begin
    if (!rst && we_b) begin
      ram[addr_b] = din_b;
      last_addr = addr_b;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h with empty model queue", addr_b, din_b);
      end else begin
        w_chk = exp_q.pop_front();
        checks--;
        check("wr_addr", addr_b, w_chk.addr);
        check("wr_data", din_b, w_chk.data);
      end
    end
  end

  function automatic logic [7:0] sat8(input logic [31:0] a, input int sh);
    longint v;
    v = longint'($signed(a));
    v = v >>> sh;
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
    return 8'(v);
  endfunction

  task automatic build_model(input int base, input bit p8, input int sh,
                             output bit wrap, output int nwr);
    int n = 0;
    exp_q.delete();
    for (int e = 0; e < N; e++) begin
      if (p8) begin
        exp_q.push_back('{(base + n) % 1024, int'(sat8(acc_mem[e], sh))});
        n++;
      end else begin
        for (int k = 0; k < AW/DW; k++) begin
          exp_q.push_back('{(base + n) % 1024, int'((acc_mem[e] >> (8*k)) & 32'hFF)});
          n++;
        end
      end
    end
    nwr  = n;
    wrap = (base + n - 1) >= 1024;
  endtask

  task automatic run(input int base, input bit p8, input int sh,
                     input int glitch_at, input int abort_at, input string tag);
    bit wrap; int nwr;
    int c = 0, first = -1, bcnt = 0, dc = -1;
    logic wf = 1'b0;
    build_model(base, p8, sh, wrap, nwr);
    @(posedge clk); #1;
    base_addr = DAW'(base); pack_int8 = p8; shift_amt = 5'(sh); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Config is latched; scramble the inputs for the rest of the run.
    base_addr = ~DAW'(base); pack_int8 = ~p8; shift_amt = 5'(sh + 3);
    while (dc < 0 && c < 1000) begin
      @(negedge clk);
      if (we_b && first < 0) first = c;
      if (busy) bcnt++;
      if (done) begin dc = c; wf = wrap_flag; end
      if (c == glitch_at) begin start = 1'b1; base_addr = DAW'(base) ^ 10'h155; end
      else if (c == glitch_at + 1) start = 1'b0;
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        check({tag, "_abort_we_b"}, we_b, 0);
        check({tag, "_abort_busy"}, busy, 0);
        break;
      end
      c++;
    end
    if (abort_at >= 0) begin
      repeat (3) begin
        @(negedge clk);
        check({tag, "_abort_no_done"}, done, 0);
      end
      rst = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check({tag, "_post_abort_idle"}, {busy, done, we_b}, 0);
      end
      exp_q.delete();
      return;
    end
    check({tag, "_first_we_cycle"}, first, 3);
    check({tag, "_busy_cycles"}, bcnt, p8 ? 192 : 384);
    check({tag, "_done_cycle"}, dc, p8 ? 193 : 385);
    check({tag, "_wrap_at_done"}, wf, wrap);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_all_writes_seen"}, exp_q.size(), 0);
    check({tag, "_wrap_held"}, wrap_flag, wrap);
    check({tag, "_last_addr"}, last_addr, (base + nwr - 1) % 1024);
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < N; i++) acc_mem[i] = 32'(i) * 32'h1357_9BDF + 32'h0F0F;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; pack_int8 = 1'b0; shift_amt = '0;
    fill_pattern();
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrap", wrap_flag, 0);
    check("rst_we_b", we_b, 0);
    check("rst_addr_acc", addr_acc, 0);
    check("rst_addr_b", addr_b, 0);
    check("rst_din_b", din_b, 0);
    rst = 1'b0;

    // Full-width little-endian
    acc_mem[0] = 32'h1234_5678; acc_mem[1] = 32'hCAFE_BABE;
    run(16, 1'b0, 0, -1, -1, "full");
    check("full_b0", ram[16], 8'h78);
    check("full_b1", ram[17], 8'h56);
    check("full_b2", ram[18], 8'h34);
    check("full_b3", ram[19], 8'h12);
    check("full_b4", ram[20], 8'hBE);
    check("full_b7", ram[23], 8'hCA);
    check("full_last", last_addr, 12'h10F);

    // int8 requantization, shift 2
    acc_mem[0] = 32'd1000; acc_mem[1] = -32'sd1000; acc_mem[2] = 32'd100; acc_mem[3] = -32'sd5;
    run(256, 1'b1, 2, -1, -1, "int8s2");
    check("int8_pos_sat", ram[256], 8'h7F);
    check("int8_neg_sat", ram[257], 8'h80);
    check("int8_inrange", ram[258], 8'h19);

    // int8 shift 1 at base 0: no wrap
    run(0, 1'b1, 1, -1, -1, "int8s1");
    check("int8_neg_small", ram[3], 8'hFD);
    check("nowrap_last", last_addr, 63);
    check("nowrap_flag", wrap_flag, 0);

    // Wrap past the top of DP RAM
    acc_mem[0] = 32'h1234_5678; acc_mem[1] = 32'hCAFE_BABE;
    run(1020, 1'b0, 0, -1, -1, "wrap");
    check("wrap_e0_lo", ram[1020], 8'h78);
    check("wrap_e0_hi", ram[1023], 8'h12);
    check("wrap_e1_lo", ram[0], 8'hBE);
    check("wrap_e1_hi", ram[3], 8'hCA);
    check("wrap_flag", wrap_flag, 1);

    // Second start mid-run is ignored
    run(12'h040, 1'b0, 0, 50, -1, "restart");

    // Reset during element 10's writes, then a clean full drain
    run(12'h300, 1'b0, 0, -1, 64, "abort");
    run(12'h300, 1'b0, 0, -1, -1, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
